// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared opcodes and mul/div state type for the ALU + mul/div unit
package alu_md_pkg;

    localparam logic [2:0] F_AND  = 3'b000;
    localparam logic [2:0] F_OR   = 3'b001;
    localparam logic [2:0] F_ADD  = 3'b010;
    localparam logic [2:0] F_SLT  = 3'b011;
    localparam logic [2:0] F_XOR  = 3'b100;
    localparam logic [2:0] F_NOR  = 3'b101;
    localparam logic [2:0] F_SLTU = 3'b110;
    localparam logic [2:0] F_ZERO = 3'b111;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply / restoring divide writing hi/lo
module muldiv_seq
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_e          state, next;
    logic [1:0]         op;
    logic               sa, sb;
    logic [WIDTH-1:0]   ma, mb;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH:0]     shl, rem_next;
    logic               ge;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // operand magnitudes (bit 0 of md_op marks the signed variants), one
    // iteration of each algorithm, and the final sign correction
    always_comb begin
        abs_a    = (md_op[0] && a[WIDTH-1]) ? -a : a;
        abs_b    = (md_op[0] && b[WIDTH-1]) ? -b : b;
        mul_add  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
        mul_next = {mul_add, acc[WIDTH-1:1]};
        shl      = {rem[WIDTH-1:0], acc[WIDTH-1]};
        ge       = shl >= {1'b0, mb};
        rem_next = ge ? shl - {1'b0, mb} : shl;
        div_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
        prod     = (sa ^ sb) ? -acc : acc;
        fix_hi   = !op[1] ? prod[2*WIDTH-1:WIDTH] :
                   (mb == '0) ? (sa ? -ma : ma) :
                   sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        fix_lo   = !op[1] ? prod[WIDTH-1:0] :
                   (mb == '0) ? '1 :
                   (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // next-state: accept start only when idle, run WIDTH iterations, then fix
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? RUN : IDLE;
            RUN:     next = (cnt == '0) ? FIX : RUN;
            FIX:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    // datapath: latch operands, iterate, write results in FIX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op   <= '0;
            sa   <= 1'b0;
            sb   <= 1'b0;
            ma   <= '0;
            mb   <= '0;
            acc  <= '0;
            rem  <= '0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= state == FIX;
            case (state)
                IDLE: if (start) begin
                    op  <= md_op;
                    sa  <= md_op[0] & a[WIDTH-1];
                    sb  <= md_op[0] & b[WIDTH-1];
                    ma  <= abs_a;
                    mb  <= abs_b;
                    acc <= {{WIDTH{1'b0}}, abs_a};
                    rem <= '0;
                    cnt <= CW'(WIDTH - 1);
                end
                RUN: begin
                    acc <= op[1] ? div_next : mul_next;
                    rem <= op[1] ? rem_next : rem;
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy = state != IDLE;

endmodule

// File: rtl/alu_md.sv
// alu_md: single-cycle MIPS ALU with an attached sequential mul/div unit
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    input  logic             start,
    input  logic [1:0]       md_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] bb, s;
    logic [WIDTH:0]   sum;
    logic             cout, ovf;

    assign bb   = f[3] ? ~b : b;
    assign sum  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, f[3]};
    assign s    = sum[WIDTH-1:0];
    assign cout = sum[WIDTH];
    assign ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);

    // result select on the low three function bits
    always_comb begin
        y = '0;
        case (f[2:0])
            F_AND:   y = a & bb;
            F_OR:    y = a | bb;
            F_ADD:   y = s;
            F_SLT:   y = {{(WIDTH-1){1'b0}}, s[WIDTH-1] ^ ovf};
            F_XOR:   y = a ^ bb;
            F_NOR:   y = ~(a | bb);
            F_SLTU:  y = {{(WIDTH-1){1'b0}}, ~cout};
            default: y = '0;
        endcase
    end

    assign zero = y == '0;

    muldiv_seq #(.WIDTH(WIDTH)) u_md (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

endmodule
